uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between several maneuver controllers (turn_left, turn_right, forward, stop, etc.), each of which drives its own tx_data/tx_valid pair. Eligible requests are granted round-robin. The winning byte is latched and presented to the UART under its tx_ready/tx_valid handshake, and the source is acknowledged. Sits between the maneuver FSMs and the UART transmitter in the top-level robot controller.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 1000, idle clock cycles inserted after each transferred byte (0 = none)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  N_REQ  per-requester byte-valid (level)
- req_data  input  8*N_REQ  requester i byte on bits [8*i+7:8*i]
- req_ack  output  N_REQ  one-cycle pulse: requester i byte transferred
- tx_ready  input  1  UART can accept a byte
- tx_data  output  8  byte to UART
- tx_valid  output  1  tx_data valid
- grant_id  output  3  index of current/last granted requester
- busy  output  1  high in SEND or GAP

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - Eligible set = req_valid, masked by the dedup rule when configured.
  - If the set is non-empty, pick the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - Latch its req_data into tx_data, set tx_valid=1, set grant_id, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - tx_valid held 1 and tx_data held stable until a clock edge with tx_ready=1; that edge is the transfer.
  - On transfer: tx_valid->0; req_ack[grant_id] pulses for the next cycle only; rr_ptr -> (grant_id+1) mod N_REQ.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - 16-bit counter counts from 0.
  - Returns to IDLE after exactly GAP_CYCLES cycles in GAP.
  - No grants are made during GAP.
- A latched byte is committed. If the requester drops req_valid or changes req_data during SEND, the latched byte is still sent and still acked.
- If tx_ready is stuck low, the block stays in SEND indefinitely (no timeout).
- Requests arriving during SEND or GAP wait; a request not re-evaluated until IDLE is not lost while it is held.
- All N_REQ requesters valid at once: each is served once in rr_ptr order before any is served twice.

## Timing
- Reset (reset=0 at an edge) forces, on the following cycle:
  - state=IDLE, tx_valid=0, tx_data=0, req_ack=0, grant_id=0, busy=0, rr_ptr=0, gap counter=0, dedup history cleared.
- Reset mid-SEND drops tx_valid the next cycle; the byte is abandoned and no ack is given.
- All outputs are registered.
- Latency from req_valid high in IDLE (tx_ready=1) to transfer:
  - Edge 1: grant; tx_valid rises.
  - Edge 2: transfer.
  - req_ack is high in the cycle after edge 2.
- Minimum byte period per transfer = 2 + GAP_CYCLES cycles.
- busy rises with tx_valid. It falls on the edge that enters IDLE.

## Configuration
- UART_TX_ARB_DEDUP_EN defined:
  - After requester i is acked, it becomes ineligible while req_valid[i] stays high and req_data[i] equals the last byte sent from i.
  - It becomes eligible again when req_valid[i] goes low for at least one cycle, or req_data[i] changes.
  - This lets maneuver FSMs hold tx_valid high for a whole state and still emit one byte.
- Not defined:
  - Pure level-sensitive arbitration; a continuously held request is re-sent every 2+GAP_CYCLES cycles, subject to round-robin.
  - No per-requester history registers.

## Test plan
- Single request, GAP_CYCLES=4, tx_ready=1: req_valid=4'b0001, data 8'd68 -> tx_valid high for 1 cycle with tx_data=68 at edge 1, req_ack=4'b0001 one cycle, busy low 6 cycles after grant.
- Contention: req_valid=4'b1111, data 65/66/67/68, rr_ptr=0 -> bytes 65,66,67,68,65 in order; no requester served twice before all are served once.
- Backpressure: tx_ready=0 for 20 cycles after grant -> tx_valid and tx_data=82 held stable 20 cycles; transfer and ack on first edge with tx_ready=1; requester dropping req_valid meanwhile does not cancel the byte.
- Reset mid-SEND: reset=0 during SEND -> next cycle tx_valid=0, req_ack=0, grant_id=0, busy=0; after release, a held request is granted starting from requester 0.
- Dedup (macro defined): requester 2 holds valid with data 8'd76 for 5000 cycles -> exactly one transfer. Change data to 8'd82 -> one more transfer. Without the macro, the same stimulus gives repeated 76 bytes every 2+GAP_CYCLES cycles.
- GAP_CYCLES=0, two requesters valid: back-to-back transfers; next tx_valid rises the cycle after the previous transfer.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART side bundle for uart_tx_arbiter.
// slave = arbiter view, master = environment view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic [2:0]         grant_id;
  logic               busy;

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ack, tx_data, tx_valid, grant_id, busy
  );

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ack, tx_data, tx_valid, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Define UART_TX_ARB_DEDUP_EN to suppress re-sending a byte that is held unchanged.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 1000
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [15:0]     gap_cnt;
  logic [7:0]      elig;
  logic [7:0][7:0] data_arr;
  logic            pick_vld;
  logic [2:0]      pick_idx;
  logic [3:0]      cand;
  logic [7:0]      ack_vec;

  // Pad to 8 lanes so a 3-bit index always fits exactly.
  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_lane
      if (i < N_REQ) begin : g_act
        assign data_arr[i] = bus.req_data[8*i +: 8];
`ifdef UART_TX_ARB_DEDUP_EN
        logic       hv;
        logic [7:0] hb;
        // Last byte sent from this lane; forgotten once valid drops or data moves.
        always_ff @(posedge clk) begin
          if (!reset) begin
            hv <= 1'b0;
            hb <= 8'd0;
          end else if (state == SEND && bus.tx_ready && bus.grant_id == 3'(i)) begin
            hv <= 1'b1;
            hb <= bus.tx_data;
          end else if (!bus.req_valid[i] || bus.req_data[8*i +: 8] != hb) begin
            hv <= 1'b0;
          end
        end
        assign elig[i] = bus.req_valid[i] && !(hv && bus.req_data[8*i +: 8] == hb);
`else
        assign elig[i] = bus.req_valid[i];
`endif
      end else begin : g_pad
        assign data_arr[i] = 8'd0;
        assign elig[i]     = 1'b0;
      end
    end
  endgenerate

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    cand     = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (elig[cand[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[2:0];
      end
    end
  end

  assign ack_vec = 8'd1 << bus.grant_id;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'd0;
      bus.req_ack  <= '0;
      bus.grant_id <= 3'd0;
      bus.busy     <= 1'b0;
      rr_ptr       <= 3'd0;
      gap_cnt      <= 16'd0;
    end else begin
      bus.req_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.tx_data  <= data_arr[pick_idx];
            bus.tx_valid <= 1'b1;
            bus.grant_id <= pick_idx;
            bus.busy     <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          // Committed byte: only tx_ready ends this state.
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.req_ack  <= ack_vec[N_REQ-1:0];
            rr_ptr       <= (bus.grant_id == 3'(N_REQ - 1)) ? 3'd0 : bus.grant_id + 3'd1;
            gap_cnt      <= 16'd0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            gap_cnt  <= 16'd0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, a per-cycle behavioural model
// for the GAP_CYCLES=4 instance, and a GAP_CYCLES=0 instance checked by hand.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 4;
`ifdef UART_TX_ARB_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus0 ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus1 ();

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0))   u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: one committed byte at a time, then GAP idle cycles.
  logic         exp_valid = 1'b0;
  logic         exp_busy  = 1'b0;
  logic [7:0]   exp_data  = 8'd0;
  logic [N-1:0] exp_ack   = '0;
  int           exp_gid   = 0;
  int           m_ptr     = 0;
  int           m_gap_left = 0;
  bit           m_hv [N];
  logic [7:0]   m_hb [N];

  always @(posedge clk) begin : model
    logic [7:0] d [N];
    bit         el [N];
    int         pick;
    for (int i = 0; i < N; i++) begin
      d[i]  = bus0.req_data[8*i +: 8];
      el[i] = bus0.req_valid[i] && !(DEDUP && m_hv[i] && d[i] == m_hb[i]);
    end
    exp_ack = '0;
    if (!reset) begin
      exp_valid = 1'b0; exp_busy = 1'b0; exp_data = 8'd0; exp_gid = 0;
      m_ptr = 0; m_gap_left = 0;
      for (int i = 0; i < N; i++) begin m_hv[i] = 1'b0; m_hb[i] = 8'd0; end
    end else begin
      for (int i = 0; i < N; i++)
        if (!bus0.req_valid[i] || d[i] != m_hb[i]) m_hv[i] = 1'b0;
      if (exp_valid) begin
        if (bus0.tx_ready) begin
          exp_valid = 1'b0;
          exp_ack[exp_gid] = 1'b1;
          m_ptr = (exp_gid + 1) % N;
          m_hv[exp_gid] = 1'b1;
          m_hb[exp_gid] = exp_data;
          m_gap_left = GAP;
          if (GAP == 0) exp_busy = 1'b0;
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
        if (m_gap_left == 0) exp_busy = 1'b0;
      end else begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && el[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        if (pick >= 0) begin
          exp_valid = 1'b1; exp_data = d[pick]; exp_gid = pick; exp_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_tx_valid", bus0.tx_valid, exp_valid);
      check("cyc_busy", bus0.busy, exp_busy);
      check("cyc_req_ack", bus0.req_ack, exp_ack);
      check("cyc_grant_id", bus0.grant_id, exp_gid);
      if (exp_valid) check("cyc_tx_data", bus0.tx_data, exp_data);
    end
  end

  int         n_xfer = 0;
  logic [7:0] xq [$];
  always @(posedge clk)
    if (reset && bus0.tx_valid && bus0.tx_ready) begin
      n_xfer++;
      xq.push_back(bus0.tx_data);
    end

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((bus0.busy || bus0.tx_valid) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(bus0.busy || bus0.tx_valid), 0);
  endtask

  initial begin
    int stable;
    int odd;
    logic [4:0] vpat;
    logic [4:0] bpat;
    logic [N-1:0] a1;
    logic [N-1:0] a3;
    logic [7:0] d2;
    bus0.req_valid = '0; bus0.req_data = '0; bus0.tx_ready = 1'b1;
    bus1.req_valid = '0; bus1.req_data = '0; bus1.tx_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx_valid", bus0.tx_valid, 0);
    check("rst_tx_data", bus0.tx_data, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_grant_id", bus0.grant_id, 0);
    check("rst_req_ack", bus0.req_ack, 0);
    check("rst_u1_tx_valid", bus1.tx_valid, 0);
    reset = 1'b1;

    // Single request, GAP=4
    bus0.req_data = {8'd0, 8'd0, 8'd0, 8'd68};
    bus0.req_valid = 4'b0001;
    @(negedge clk);
    check("t1_valid", bus0.tx_valid, 1);
    check("t1_data", bus0.tx_data, 68);
    check("t1_gid", bus0.grant_id, 0);
    check("t1_busy", bus0.busy, 1);
    check("t1_model_data", exp_data, 68);
    bus0.req_valid = '0;
    @(negedge clk);
    check("t1_valid_drop", bus0.tx_valid, 0);
    check("t1_ack", bus0.req_ack, 4'b0001);
    @(negedge clk);
    check("t1_ack_pulse", bus0.req_ack, 0);
    repeat (2) @(negedge clk);
    check("t1_busy_gap", bus0.busy, 1);
    @(negedge clk);
    check("t1_busy_fall", bus0.busy, 0);
    check("t1_model_busy", exp_busy, 0);

    // Contention from rr_ptr=0
    do_reset();
    n_xfer = 0; xq.delete();
    bus0.req_data = {8'd68, 8'd67, 8'd66, 8'd65};
    bus0.req_valid = 4'b1111;
    for (int c = 0; c < 60 && n_xfer < 5; c++) @(negedge clk);
    bus0.req_valid = '0;
    check("t2_count", n_xfer, DEDUP ? 4 : 5);
    for (int i = 0; i < 4; i++)
      check("t2_byte", (xq.size() > i) ? xq[i] : 8'd0, 65 + i);
    check("t2_byte4", (xq.size() > 4) ? xq[4] : 8'd0, DEDUP ? 0 : 65);
    wait_idle("t2_idle");

    // Backpressure with requester withdrawing after grant
    do_reset();
    bus0.tx_ready = 1'b0;
    bus0.req_data = {8'd0, 8'd0, 8'd82, 8'd0};
    bus0.req_valid = 4'b0010;
    @(negedge clk);
    check("t3_grant_valid", bus0.tx_valid, 1);
    check("t3_grant_gid", bus0.grant_id, 1);
    bus0.req_valid = '0;
    bus0.req_data = '0;
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.tx_valid === 1'b1 && bus0.tx_data === 8'd82) stable++;
    end
    check("t3_hold", stable, 20);
    bus0.tx_ready = 1'b1;
    @(negedge clk);
    check("t3_xfer_valid", bus0.tx_valid, 0);
    check("t3_ack", bus0.req_ack, 4'b0010);
    wait_idle("t3_idle");

    // Reset mid-SEND; rr_ptr is 2 here
    bus0.tx_ready = 1'b0;
    bus0.req_data = {8'h33, 8'h00, 8'h31, 8'h00};
    bus0.req_valid = 4'b1010;
    @(negedge clk);
    check("t4_gid_pre", bus0.grant_id, 3);
    reset = 1'b0;
    @(negedge clk);
    check("t4_rst_valid", bus0.tx_valid, 0);
    check("t4_rst_ack", bus0.req_ack, 0);
    check("t4_rst_gid", bus0.grant_id, 0);
    check("t4_rst_busy", bus0.busy, 0);
    reset = 1'b1;
    bus0.tx_ready = 1'b1;
    @(negedge clk);
    check("t4_regrant_gid", bus0.grant_id, 1);
    check("t4_regrant_data", bus0.tx_data, 8'h31);
    @(negedge clk);
    check("t4_ack", bus0.req_ack, 4'b0010);
    bus0.req_valid = '0;
    wait_idle("t4_idle");

    // Held request: dedup vs level-sensitive resend
    n_xfer = 0; xq.delete();
    bus0.req_data = {8'd0, 8'd76, 8'd0, 8'd0};
    bus0.req_valid = 4'b0100;
    repeat (600) @(negedge clk);
    check("t5_count76", n_xfer, DEDUP ? 1 : 100);
    odd = 0;
    foreach (xq[i]) if (xq[i] != 8'd76) odd++;
    check("t5_bytes76", odd, 0);
    n_xfer = 0; xq.delete();
    bus0.req_data = {8'd0, 8'd82, 8'd0, 8'd0};
    repeat (600) @(negedge clk);
    check("t5_count82", n_xfer, DEDUP ? 1 : 100);
    check("t5_first82", (xq.size() > 0) ? xq[0] : 8'd0, 82);
    bus0.req_valid = '0;
    wait_idle("t5_idle");

    // GAP_CYCLES=0 instance: back-to-back
    bus1.req_data = {8'd0, 8'd0, 8'h22, 8'h11};
    bus1.req_valid = 4'b0011;
    vpat = '0; bpat = '0; a1 = '0; a3 = '0; d2 = '0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      vpat[e] = bus1.tx_valid;
      bpat[e] = bus1.busy;
      if (e == 1) a1 = bus1.req_ack;
      if (e == 3) a3 = bus1.req_ack;
      if (e == 2) d2 = bus1.tx_data;
    end
    bus1.req_valid = '0;
    check("t6_valid_pat", vpat, DEDUP ? 5'b00101 : 5'b10101);
    check("t6_busy_pat", bpat, DEDUP ? 5'b00101 : 5'b10101);
    check("t6_ack0", a1, 4'b0001);
    check("t6_ack1", a3, 4'b0010);
    check("t6_data1", d2, 8'h22);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
